// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe register pipeline.
package dff_pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Bits needed to hold the values 0..n inclusive (never less than 1).
    function automatic int clog2_p1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n + 1) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline slot: a valid bit plus a data register, loading from upstream
// whenever its content can leave (adv) or it is empty.
module dff_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             adv,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v_out,
    output logic [WIDTH-1:0] d_out
);

    // An empty slot always accepts, which is what collapses bubbles.
    logic load;
    assign load = adv || !v_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            v_out <= 1'b0;
            d_out <= RESET_VAL;
        end else if (flush) begin
            v_out <= 1'b0;
        end else if (load) begin
            v_out <= v_in;
            d_out <= d_in;
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// Multi-stage ready/valid register pipeline with bubble collapsing, flush and
// an occupancy counter. Outputs come straight from the last-stage registers.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [clog2_p1(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = clog2_p1(DEPTH);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic [DEPTH-1:0]            adv;
    logic                        in_fire;
    logic                        out_fire;

    // adv[i]: stage i's content may move on because stage i+1 will load.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = !v[i+1] || adv[i+1];
        end
    end

    assign in_ready  = (!v[0] || adv[0]) && !flush;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign out_fire  = out_valid && out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             sv;
        logic [WIDTH-1:0] sd;
        if (i == 0) begin : g_head
            assign sv = in_fire;
            assign sd = in_data;
        end else begin : g_body
            assign sv = v[i-1];
            assign sd = d[i-1];
        end
        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .adv   (adv[i]),
            .v_in  (sv),
            .d_in  (sd),
            .v_out (v[i]),
            .d_out (d[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OCC_W'(in_fire) - OCC_W'(out_fire);
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: a DEPTH=4 byte pipe and a DEPTH=1 32-bit pipe.
module tb_dff_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_data, out_data;
    logic [2:0]  occupancy;

    logic        reset2, flush2, in_valid2, in_ready2, out_valid2, out_ready2;
    logic [31:0] in_data2, out_data2;
    logic [0:0]  occupancy2;

    int checks = 0;
    int errors = 0;

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy)
    );

    dff_pipe #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'hDEADBEEF)) dut2 (
        .clk(clk), .reset(reset2), .flush(flush2),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready2),
        .occupancy(occupancy2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Occupancy must always equal the number of valid stages.
    always @(negedge clk) begin
        if (!reset)  chk("occ_popcount",  64'(occupancy),  64'($countones(dut.v)));
        if (!reset2) chk("occ2_popcount", 64'(occupancy2), 64'($countones(dut2.v)));
    end

    logic [7:0] bp_d [5];
    int         bp_o [5];
    logic [7:0] st_d [4];
    int         st_o [4];
    logic       st_v [4];

    initial begin
        reset = 1; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
        reset2 = 1; flush2 = 0; in_valid2 = 0; in_data2 = '0; out_ready2 = 0;

        // Reset
        repeat (2) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data, 8'h00);
        chk("rst_occ",       occupancy, 0);
        chk("rst_in_ready",  in_ready, 1);
        reset = 0;

        // Streaming: accept at edges 1..3, first word shown after edge 4
        out_ready = 1; in_valid = 1; in_data = 8'h11;
        tick(); chk("st_occ1", occupancy, 1);
        in_data = 8'h22;
        tick(); chk("st_occ2", occupancy, 2);
        in_data = 8'h33;
        tick(); chk("st_occ3", occupancy, 3); chk("st_early_valid", out_valid, 0);
        in_valid = 0;
        st_v = '{1, 1, 1, 0};
        st_d = '{8'h11, 8'h22, 8'h33, 8'h33};
        st_o = '{3, 2, 1, 0};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("st_valid", out_valid, st_v[k]);
            if (st_v[k]) chk("st_data", out_data, st_d[k]);
            chk("st_occ", occupancy, st_o[k]);
        end

        // Backpressure: fill to 4, then release
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hA0 + 8'(i);
            #1 chk("bp_in_ready_fill", in_ready, 1);
            tick();
        end
        in_data = 8'hA4;
        #1;
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_full_occ", occupancy, 4);
        chk("bp_head", out_data, 8'hA0);
        out_ready = 1;
        #1 chk("bp_ready_same_cycle", in_ready, 1);
        bp_d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        bp_o = '{4, 4, 3, 2, 1};
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) in_data = 8'hA5;
            if (k == 1) in_valid = 0;
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, bp_d[k]);
            chk("bp_occ", occupancy, bp_o[k]);
        end
        tick();
        chk("bp_drained_valid", out_valid, 0);
        chk("bp_drained_occ", occupancy, 0);

        // Bubble collapse: build v=1010 under backpressure, push one word
        out_ready = 0;
        in_valid = 1; in_data = 8'hB0; tick();
        in_valid = 0;                  tick();
        in_valid = 1; in_data = 8'hB1; tick();
        in_valid = 0;                  tick();
        chk("bub_v_pattern", dut.v, 4'b1010);
        chk("bub_occ2", occupancy, 2);
        in_valid = 1; in_data = 8'hB2;
        #1 chk("bub_in_ready", in_ready, 1);
        tick();
        in_valid = 0;
        chk("bub_v_after", dut.v, 4'b1101);
        chk("bub_occ3", occupancy, 3);
        chk("bub_head", out_data, 8'hB0);

        // Flush with traffic on both sides
        flush = 1; in_valid = 1; in_data = 8'hFF; out_ready = 1;
        #1;
        chk("fl_in_ready", in_ready, 0);
        chk("fl_out_valid", out_valid, 1);
        chk("fl_out_data", out_data, 8'hB0);
        tick();
        flush = 0; in_valid = 0; out_ready = 0;
        chk("fl_occ", occupancy, 0);
        chk("fl_out_valid_after", out_valid, 0);
        chk("fl_v", dut.v, 4'b0000);
        chk("fl_data_kept", out_data, 8'hB0);
        #1 chk("fl_in_ready_after", in_ready, 1);

        // Reset mid-stream together with flush
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hC0 + 8'(i);
            tick();
        end
        in_valid = 0;
        chk("rm_occ_full", occupancy, 4);
        chk("rm_head", out_data, 8'hC0);
        reset = 1; flush = 1;
        tick();
        chk("rm_out_valid", out_valid, 0);
        chk("rm_out_data", out_data, 8'h00);
        chk("rm_occ", occupancy, 0);
        chk("rm_v", dut.v, 4'b0000);
        reset = 0; flush = 0;

        // DEPTH=1, WIDTH=32
        chk("d1_rst_in_ready", in_ready2, 1);
        chk("d1_rst_valid", out_valid2, 0);
        chk("d1_rst_data", out_data2, 32'hDEADBEEF);
        chk("d1_rst_occ", occupancy2, 0);
        reset2 = 0;
        in_valid2 = 1; in_data2 = 32'h12345678;
        tick();
        in_valid2 = 0;
        chk("d1_valid", out_valid2, 1);
        chk("d1_data", out_data2, 32'h12345678);
        chk("d1_occ", occupancy2, 1);
        #1 chk("d1_full_in_ready", in_ready2, 0);
        in_valid2 = 1; in_data2 = 32'hCAFEF00D; out_ready2 = 1;
        #1 chk("d1_ready_same_cycle", in_ready2, 1);
        tick();
        in_valid2 = 0; out_ready2 = 0;
        chk("d1_thru_data", out_data2, 32'hCAFEF00D);
        chk("d1_thru_occ", occupancy2, 1);
        reset2 = 1; flush2 = 1;
        tick();
        chk("d1_rm_valid", out_valid2, 0);
        chk("d1_rm_data", out_data2, 32'hDEADBEEF);
        chk("d1_rm_occ", occupancy2, 0);
        reset2 = 0; flush2 = 0;

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
